// File: rtl/axi_cnt_pkg.sv
// Shared types and constants for the AXI counter master.
// The FSM walks one single-beat write followed by a read-back.

package axi_cnt_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWr,
        StWresp,
        StRda,
        StRdd,
        StChk
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int unsigned DEF_ID_W     = 4;
    localparam int unsigned DEF_DATA_W   = 32;
    localparam int unsigned DEF_NUM_REGS = 8;
    localparam int unsigned DEF_TIMEOUT  = 256;

endpackage

// File: rtl/axi_cnt_wr_issue.sv
// Issues the AW and W beats of one write together and retires each on its own handshake.
// all_done_o is high once both channels have handshaken, including in the handshake cycle.

module axi_cnt_wr_issue (
    input  logic clk,
    input  logic areset,
    input  logic start_i,
    input  logic awready_i,
    input  logic wready_i,
    output logic awvalid_o,
    output logic wvalid_o,
    output logic all_done_o
);

    logic awvalid_q, wvalid_q;
    logic aw_done_q, w_done_q;
    logic aw_hs, w_hs;

    assign aw_hs = awvalid_q && awready_i;
    assign w_hs  = wvalid_q && wready_i;

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else if (start_i) begin
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            if (aw_hs) begin
                awvalid_q <= 1'b0;
                aw_done_q <= 1'b1;
            end
            if (w_hs) begin
                wvalid_q <= 1'b0;
                w_done_q <= 1'b1;
            end
        end
    end

    assign awvalid_o  = awvalid_q;
    assign wvalid_o   = wvalid_q;
    assign all_done_o = (aw_done_q || aw_hs) && (w_done_q || w_hs);

endmodule

// File: rtl/axi_cnt_master.sv
// AXI single-beat master: writes a running counter to register IDX, reads it back and compares.
// IDX walks 0..NUM_REGS-1 and wraps; status is sticky until reset.

module axi_cnt_master
    import axi_cnt_pkg::*;
#(
    parameter int unsigned ID_W     = DEF_ID_W,
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned NUM_REGS = DEF_NUM_REGS,
    parameter int unsigned AXI_ID   = 0,
    parameter int unsigned TIMEOUT  = DEF_TIMEOUT
) (
    input  logic                clk,
    input  logic                areset,
    input  logic                en_i,
    output logic [ID_W-1:0]     awid_o,
    output logic [31:0]         awaddr_o,
    output logic                awvalid_o,
    input  logic                awready_i,
    output logic [ID_W-1:0]     wid_o,
    output logic [DATA_W-1:0]   wdata_o,
    output logic [DATA_W/8-1:0] wstrb_o,
    output logic                wlast_o,
    output logic                wvalid_o,
    input  logic                wready_i,
    input  logic [ID_W-1:0]     bid_i,
    input  logic [1:0]          bresp_i,
    input  logic                bvalid_i,
    output logic                bready_o,
    output logic [ID_W-1:0]     arid_o,
    output logic [31:0]         araddr_o,
    output logic                arvalid_o,
    input  logic                arready_i,
    input  logic [ID_W-1:0]     rid_i,
    input  logic [DATA_W-1:0]   rdata_i,
    input  logic                rvalid_i,
    output logic                rready_o,
    output logic [DATA_W-1:0]   cnt_o,
    output logic [7:0]          mism_o,
    output logic                err_o,
    output logic                timeout_o,
    output logic                done_o
);

    localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int unsigned WD_W  = $clog2(TIMEOUT + 1);

    state_t              state_q;
    logic [IDX_W-1:0]    idx_q;
    logic [DATA_W-1:0]   val_q, next_q, rdata_q, cnt_q;
    logic [7:0]          mism_q;
    logic                err_q, timeout_q, done_q;
    logic                bready_q, arvalid_q, rready_q;
    logic [WD_W-1:0]     wdog_q;
    logic                wr_start, wr_all_done, advance, waiting;

    // Only one transaction is ever outstanding, so response IDs carry no information.
    logic unused_ids;
    assign unused_ids = ^{bid_i, rid_i};

    assign wr_start = (state_q == StIdle) && en_i;

    axi_cnt_wr_issue u_wr_issue (
        .clk        (clk),
        .areset     (areset),
        .start_i    (wr_start),
        .awready_i  (awready_i),
        .wready_i   (wready_i),
        .awvalid_o  (awvalid_o),
        .wvalid_o   (wvalid_o),
        .all_done_o (wr_all_done)
    );

    always_comb begin
        advance = 1'b0;
        unique case (state_q)
            StIdle:  advance = en_i;
            StWr:    advance = wr_all_done;
            StWresp: advance = bvalid_i;
            StRda:   advance = arready_i;
            StRdd:   advance = rvalid_i;
            StChk:   advance = 1'b1;
            default: advance = 1'b0;
        endcase
    end

    assign waiting = (state_q == StWr) || (state_q == StWresp) ||
                     (state_q == StRda) || (state_q == StRdd);

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            val_q     <= '0;
            next_q    <= DATA_W'(1);
            rdata_q   <= '0;
            cnt_q     <= '0;
            mism_q    <= '0;
            err_q     <= 1'b0;
            timeout_q <= 1'b0;
            done_q    <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            wdog_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: if (advance) begin
                    val_q   <= next_q;
                    state_q <= StWr;
                end
                StWr: if (advance) begin
                    bready_q <= 1'b1;
                    state_q  <= StWresp;
                end
                StWresp: if (advance) begin
                    if (bresp_i != RESP_OKAY) err_q <= 1'b1;
                    bready_q  <= 1'b0;
                    arvalid_q <= 1'b1;
                    state_q   <= StRda;
                end
                StRda: if (advance) begin
                    arvalid_q <= 1'b0;
                    rready_q  <= 1'b1;
                    state_q   <= StRdd;
                end
                StRdd: if (advance) begin
                    rdata_q  <= rdata_i;
                    rready_q <= 1'b0;
                    state_q  <= StChk;
                end
                StChk: begin
                    if (rdata_q != val_q) begin
                        err_q <= 1'b1;
                        if (mism_q != 8'hFF) mism_q <= mism_q + 8'd1;
                    end
                    cnt_q   <= val_q;
                    done_q  <= 1'b1;
                    next_q  <= val_q + DATA_W'(1);
                    idx_q   <= (idx_q == IDX_W'(NUM_REGS - 1)) ? '0 : idx_q + IDX_W'(1);
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase

            // Watchdog only flags the stall; the handshake is still awaited.
            if (advance) begin
                wdog_q <= '0;
            end else if (waiting) begin
                if (wdog_q != WD_W'(TIMEOUT)) wdog_q <= wdog_q + WD_W'(1);
                if (wdog_q == WD_W'(TIMEOUT - 1)) timeout_q <= 1'b1;
            end
        end
    end

    assign awid_o    = ID_W'(AXI_ID);
    assign wid_o     = ID_W'(AXI_ID);
    assign arid_o    = ID_W'(AXI_ID);
    assign awaddr_o  = 32'(idx_q);
    assign araddr_o  = 32'(idx_q);
    assign wdata_o   = val_q;
    assign wstrb_o   = '1;
    assign wlast_o   = 1'b1;
    assign bready_o  = bready_q;
    assign arvalid_o = arvalid_q;
    assign rready_o  = rready_q;
    assign cnt_o     = cnt_q;
    assign mism_o    = mism_q;
    assign err_o     = err_q;
    assign timeout_o = timeout_q;
    assign done_o    = done_q;

endmodule

// File: tb/tb_axi_cnt_master.sv
// Directed bench for axi_cnt_master with a small negedge-driven AXI slave model.
// Expected addresses, data and status are hand-computed per scenario.

module tb_axi_cnt_master;
    import axi_cnt_pkg::*;

    logic        clk, areset, en_i;
    logic [3:0]  awid_o, wid_o, arid_o, bid_i, rid_i;
    logic [31:0] awaddr_o, araddr_o, wdata_o, rdata_i, cnt_o;
    logic [3:0]  wstrb_o;
    logic        awvalid_o, awready_i, wlast_o, wvalid_o, wready_i;
    logic [1:0]  bresp_i;
    logic        bvalid_i, bready_o, arvalid_o, arready_i, rvalid_i, rready_o;
    logic [7:0]  mism_o;
    logic        err_o, timeout_o, done_o;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Slave model state
    logic        aw_hs, w_hs, b_hs, ar_hs, r_hs, got_aw, got_w, ar_block;
    int          aw_wait, aw_delay, wr_count, rd_count, bresp_err_at, corrupt_at;
    logic [31:0] aw_cap, w_cap, ar_cap;
    logic [31:0] mem [8];
    int          wr_addr_q[$];
    logic [31:0] wr_data_q[$];

    // Run bookkeeping
    int done_cyc[$];
    int start_cyc, aw_hi, w_hi;

    axi_cnt_master #(
        .ID_W(4), .DATA_W(32), .NUM_REGS(8), .AXI_ID(0), .TIMEOUT(256)
    ) dut (
        .clk(clk), .areset(areset), .en_i(en_i),
        .awid_o(awid_o), .awaddr_o(awaddr_o), .awvalid_o(awvalid_o), .awready_i(awready_i),
        .wid_o(wid_o), .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wlast_o(wlast_o),
        .wvalid_o(wvalid_o), .wready_i(wready_i),
        .bid_i(bid_i), .bresp_i(bresp_i), .bvalid_i(bvalid_i), .bready_o(bready_o),
        .arid_o(arid_o), .araddr_o(araddr_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
        .rid_i(rid_i), .rdata_i(rdata_i), .rvalid_i(rvalid_i), .rready_o(rready_o),
        .cnt_o(cnt_o), .mism_o(mism_o), .err_o(err_o), .timeout_o(timeout_o), .done_o(done_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Handshakes are decided at a falling edge and take effect at the next rising edge.
    task automatic slave_step();
        if (!areset) begin
            awready_i = 0; wready_i = 0; bvalid_i = 0; bresp_i = 0;
            arready_i = 0; rvalid_i = 0; rdata_i = 0;
            aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
            got_aw = 0; got_w = 0; aw_wait = 0;
            for (int i = 0; i < 8; i++) mem[i] = 32'd0;
            return;
        end
        if (b_hs) bvalid_i = 0;
        if (r_hs) rvalid_i = 0;
        if (aw_hs) got_aw = 1;
        if (w_hs) got_w = 1;
        if (got_aw && got_w) begin
            mem[int'(aw_cap[2:0])] = w_cap;
            wr_addr_q.push_back(int'(aw_cap));
            wr_data_q.push_back(w_cap);
            wr_count++;
            bresp_i = (wr_count == bresp_err_at) ? RESP_SLVERR : RESP_OKAY;
            bvalid_i = 1;
            got_aw = 0;
            got_w = 0;
        end
        if (ar_hs) begin
            rd_count++;
            rdata_i = mem[int'(ar_cap[2:0])] ^ ((rd_count == corrupt_at) ? 32'd1 : 32'd0);
            rvalid_i = 1;
        end
        awready_i = awvalid_o && (aw_wait >= aw_delay);
        if (awvalid_o && !awready_i) aw_wait++;
        aw_hs = awvalid_o && awready_i;
        if (aw_hs) begin
            aw_cap = awaddr_o;
            aw_wait = 0;
        end
        wready_i = wvalid_o;
        w_hs = wvalid_o && wready_i;
        if (w_hs) w_cap = wdata_o;
        b_hs = bvalid_i && bready_o;
        arready_i = arvalid_o && !ar_block;
        ar_hs = arvalid_o && arready_i;
        if (ar_hs) ar_cap = araddr_o;
        r_hs = rvalid_i && rready_o;
    endtask

    initial forever begin
        @(negedge clk);
        slave_step();
    end

    task automatic run_txns(input string name, input int n, input int budget);
        int seen = 0;
        int t = 0;
        done_cyc.delete();
        aw_hi = 0;
        w_hi = 0;
        start_cyc = cyc;
        en_i = 1;
        while (seen < n && t < budget) begin
            @(negedge clk);
            t++;
            if (awvalid_o) aw_hi++;
            if (wvalid_o) w_hi++;
            if (done_o) begin
                seen++;
                done_cyc.push_back(cyc);
                if (seen == n) en_i = 0;
            end
        end
        en_i = 0;
        checks++;
        if (seen != n) begin
            errors++;
            $display("FAIL %s_done_count: got %0d want %0d", name, seen, n);
        end
    endtask

    task automatic do_reset();
        areset = 0;
        en_i = 0;
        repeat (2) @(negedge clk);
        areset = 1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        areset = 0;
        en_i = 0;
        repeat (2) @(negedge clk);
        checks++;
        if ({awvalid_o, wvalid_o, bready_o, arvalid_o, rready_o} !== 5'b0) begin
            errors++;
            $display("FAIL reset_valids: got %b want 00000",
                     {awvalid_o, wvalid_o, bready_o, arvalid_o, rready_o});
        end
        checks++;
        if ({cnt_o, mism_o, err_o, timeout_o, done_o} !== 43'd0) begin
            errors++;
            $display("FAIL reset_status: got cnt=%0d mism=%0d err=%b to=%b done=%b want all 0",
                     cnt_o, mism_o, err_o, timeout_o, done_o);
        end
        areset = 1;
        repeat (3) @(negedge clk);
        checks++;
        if (awvalid_o !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_start: got awvalid=%b want 0", awvalid_o);
        end
    endtask

    task automatic test_basic();
        wr_addr_q.delete();
        wr_data_q.delete();
        run_txns("basic", 10, 200);
        checks++;
        if (done_cyc.size() > 0 && done_cyc[0] - start_cyc !== 6) begin
            errors++;
            $display("FAIL basic_latency: got %0d want 6", done_cyc[0] - start_cyc);
        end
        for (int i = 1; i < done_cyc.size(); i++) begin
            checks++;
            if (done_cyc[i] - done_cyc[i-1] !== 6) begin
                errors++;
                $display("FAIL basic_period[%0d]: got %0d want 6", i, done_cyc[i] - done_cyc[i-1]);
            end
        end
        checks++;
        if (wr_addr_q.size() !== 10) begin
            errors++;
            $display("FAIL basic_write_count: got %0d want 10", wr_addr_q.size());
        end
        for (int i = 0; i < 10 && i < wr_addr_q.size(); i++) begin
            checks++;
            if (wr_addr_q[i] !== i % 8 || wr_data_q[i] !== 32'(i + 1)) begin
                errors++;
                $display("FAIL basic_write[%0d]: got addr=%0d data=%0d want addr=%0d data=%0d",
                         i, wr_addr_q[i], wr_data_q[i], i % 8, i + 1);
            end
        end
        checks++;
        if (cnt_o !== 32'd10 || err_o !== 1'b0) begin
            errors++;
            $display("FAIL basic_status: got cnt=%0d err=%b want cnt=10 err=0", cnt_o, err_o);
        end
        repeat (10) @(negedge clk);
        checks++;
        if (awvalid_o !== 1'b0 || wr_addr_q.size() !== 10) begin
            errors++;
            $display("FAIL basic_stops: got awvalid=%b writes=%0d want 0 and 10",
                     awvalid_o, wr_addr_q.size());
        end
    endtask

    task automatic test_aw_late();
        wr_addr_q.delete();
        wr_data_q.delete();
        aw_delay = 3;
        run_txns("aw_late", 1, 50);
        aw_delay = 0;
        // awready arrives three cycles after the on-time slot, so awvalid is seen for four
        checks++;
        if (aw_hi !== 4 || w_hi !== 1) begin
            errors++;
            $display("FAIL aw_late_valids: got aw=%0d w=%0d cycles want aw=4 w=1", aw_hi, w_hi);
        end
        checks++;
        if (wr_addr_q.size() !== 1) begin
            errors++;
            $display("FAIL aw_late_write_count: got %0d want 1", wr_addr_q.size());
        end else begin
            checks++;
            if (wr_addr_q[0] !== 2 || wr_data_q[0] !== 32'd11) begin
                errors++;
                $display("FAIL aw_late_write: got addr=%0d data=%0d want addr=2 data=11",
                         wr_addr_q[0], wr_data_q[0]);
            end
        end
        checks++;
        if (cnt_o !== 32'd11) begin
            errors++;
            $display("FAIL aw_late_cnt: got %0d want 11", cnt_o);
        end
    endtask

    task automatic test_bresp_err();
        int rd0;
        checks++;
        if (err_o !== 1'b0) begin
            errors++;
            $display("FAIL bresp_err_pre: got err=%b want 0", err_o);
        end
        rd0 = rd_count;
        wr_addr_q.delete();
        wr_data_q.delete();
        bresp_err_at = wr_count + 1;
        run_txns("bresp", 1, 50);
        bresp_err_at = -1;
        checks++;
        if (err_o !== 1'b1 || mism_o !== 8'd0) begin
            errors++;
            $display("FAIL bresp_err_status: got err=%b mism=%0d want err=1 mism=0", err_o, mism_o);
        end
        checks++;
        if (rd_count - rd0 !== 1 || cnt_o !== 32'd12) begin
            errors++;
            $display("FAIL bresp_err_readback: got reads=%0d cnt=%0d want reads=1 cnt=12",
                     rd_count - rd0, cnt_o);
        end
    endtask

    task automatic test_mismatch();
        wr_addr_q.delete();
        wr_data_q.delete();
        corrupt_at = rd_count + 2;
        run_txns("mismatch", 2, 50);
        corrupt_at = -1;
        checks++;
        if (mism_o !== 8'd1 || err_o !== 1'b1) begin
            errors++;
            $display("FAIL mismatch_status: got mism=%0d err=%b want mism=1 err=1", mism_o, err_o);
        end
        checks++;
        if (cnt_o !== 32'd2) begin
            errors++;
            $display("FAIL mismatch_cnt: got %0d want 2", cnt_o);
        end
        checks++;
        if (wr_addr_q.size() !== 2 || wr_data_q[0] !== 32'd1 || wr_data_q[1] !== 32'd2) begin
            errors++;
            $display("FAIL mismatch_writes: got n=%0d want 2 writes of data 1,2", wr_addr_q.size());
        end
    endtask

    task automatic test_timeout();
        int t = 0;
        bit seen_done = 0;
        wr_addr_q.delete();
        wr_data_q.delete();
        ar_block = 1;
        en_i = 1;
        while (!arvalid_o && t < 20) begin
            @(negedge clk);
            t++;
        end
        en_i = 0;
        checks++;
        if (!arvalid_o) begin
            errors++;
            $display("FAIL timeout_reach_rda: got arvalid=0 want 1 within 20 cycles");
        end
        repeat (255) @(negedge clk);
        checks++;
        if (timeout_o !== 1'b0) begin
            errors++;
            $display("FAIL timeout_early: got timeout=%b want 0 after 255 cycles", timeout_o);
        end
        @(negedge clk);
        checks++;
        if (timeout_o !== 1'b1) begin
            errors++;
            $display("FAIL timeout_set: got timeout=%b want 1 after 256 cycles", timeout_o);
        end
        repeat (43) @(negedge clk);
        checks++;
        if (arvalid_o !== 1'b1 || timeout_o !== 1'b1) begin
            errors++;
            $display("FAIL timeout_hold: got arvalid=%b timeout=%b want 1 1", arvalid_o, timeout_o);
        end
        ar_block = 0;
        t = 0;
        while (!seen_done && t < 20) begin
            @(negedge clk);
            t++;
            if (done_o) seen_done = 1;
        end
        checks++;
        if (!seen_done || cnt_o !== 32'd3) begin
            errors++;
            $display("FAIL timeout_complete: got done=%b cnt=%0d want done=1 cnt=3", seen_done, cnt_o);
        end
    endtask

    task automatic test_reset_mid();
        int t = 0;
        en_i = 1;
        while (!bready_o && t < 20) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (!bready_o) begin
            errors++;
            $display("FAIL reset_mid_reach_wresp: got bready=0 want 1 within 20 cycles");
        end
        areset = 0;
        #1;
        checks++;
        if ({awvalid_o, wvalid_o, bready_o, arvalid_o, rready_o} !== 5'b0) begin
            errors++;
            $display("FAIL reset_mid_valids: got %b want 00000",
                     {awvalid_o, wvalid_o, bready_o, arvalid_o, rready_o});
        end
        checks++;
        if (cnt_o !== 32'd0 || timeout_o !== 1'b0 || mism_o !== 8'd0) begin
            errors++;
            $display("FAIL reset_mid_status: got cnt=%0d to=%b mism=%0d want 0 0 0",
                     cnt_o, timeout_o, mism_o);
        end
        en_i = 0;
        repeat (2) @(negedge clk);
        areset = 1;
        @(negedge clk);
        wr_addr_q.delete();
        wr_data_q.delete();
        run_txns("reset_mid", 1, 50);
        checks++;
        if (wr_addr_q.size() !== 1 || wr_addr_q[0] !== 0 || wr_data_q[0] !== 32'd1) begin
            errors++;
            $display("FAIL reset_mid_first_write: got n=%0d want one write addr=0 data=1",
                     wr_addr_q.size());
        end
        checks++;
        if (cnt_o !== 32'd1) begin
            errors++;
            $display("FAIL reset_mid_cnt: got %0d want 1", cnt_o);
        end
    endtask

    initial begin
        areset = 0; en_i = 0;
        awready_i = 0; wready_i = 0; bvalid_i = 0; bresp_i = 0; bid_i = 0;
        arready_i = 0; rvalid_i = 0; rdata_i = 0; rid_i = 0;
        aw_delay = 0; ar_block = 0; wr_count = 0; rd_count = 0;
        bresp_err_at = -1; corrupt_at = -1;
        aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
        test_reset();
        test_basic();
        test_aw_late();
        test_bresp_err();
        do_reset();
        test_mismatch();
        test_timeout();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish want finish before 500000");
        $fatal(1, "bench time limit");
    end

endmodule
